// File: rtl/mips_multicycle_ctrl.sv
// Purpose : Moore-style sequencer for a shared-memory multicycle MIPS datapath
//           (lw, sw, R-type add/sub/and/or/slt, beq, addi, j).
// Latency : lw 5, sw 4, R 4, addi 4, beq 3, j 3 cycles, plus memory wait states.
// Backpressure: mem_ready=0 holds FETCH, MEMRD and MEMWR. IRWrite/PCEn follow
//           mem_ready in FETCH. MemWrite stays high until the completing cycle.
//
// Ports:
//   clk, reset          rising-edge clock; asynchronous active-high reset
//   Op, Funct           opcode and funct fields from the instruction register
//   zero                ALU zero flag, used by the branch states
//   mem_ready           shared memory port finished its access this cycle
//   PCEn, IorD, MemWrite, IRWrite, RegDest, MemtoReg, RegWrite,
//   ALUSrcA, ALUSrcB, ALUControl, PCSrc
//                       datapath controls, combinational from state and inputs
//   state               current FSM state, for debug
//   illegal             one-cycle pulse on an unsupported opcode or funct
//
// Build option: define MIPS_CTRL_BNE_EN to add bne (Op=000101) through state
// BNE=12. When it is not defined, bne is decoded as illegal and state 12 is
// handled like any other unused encoding.

module mips_multicycle_ctrl #(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         Op,
    input  logic [5:0]         Funct,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               PCEn,
    output logic               IorD,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic               RegDest,
    output logic               MemtoReg,
    output logic               RegWrite,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [2:0]         ALUControl,
    output logic [1:0]         PCSrc,
    output logic [STATE_W-1:0] state,
    output logic               illegal
);

    // ------------------------------------------------------------------
    // State encoding. The encoding is visible on the debug port, so the
    // values are fixed. Codes 12-15 are unused unless bne is built in.
    // ------------------------------------------------------------------
    typedef enum logic [STATE_W-1:0] {
        S_FETCH  = STATE_W'(0),
        S_DECODE = STATE_W'(1),
        S_MEMADR = STATE_W'(2),
        S_MEMRD  = STATE_W'(3),
        S_MEMWB  = STATE_W'(4),
        S_MEMWR  = STATE_W'(5),
        S_EXEC   = STATE_W'(6),
        S_ALUWB  = STATE_W'(7),
        S_BEQ    = STATE_W'(8),
        S_ADDIEX = STATE_W'(9),
        S_ADDIWB = STATE_W'(10),
`ifdef MIPS_CTRL_BNE_EN
        S_JUMP   = STATE_W'(11),
        S_BNE    = STATE_W'(12)
`else
        S_JUMP   = STATE_W'(11)
`endif
    } state_e;

    // Opcodes
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MIPS_CTRL_BNE_EN
    localparam logic [5:0] OP_BNE   = 6'b000101;
`endif

    // R-type funct codes
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    // ALUControl encodings
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // ALUSrcB encodings
    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    localparam logic [1:0] SRCB_IMM4 = 2'b11;

    // PCSrc encodings
    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    state_e state_q;
    state_e state_d;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (Op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
`ifdef MIPS_CTRL_BNE_EN
                    OP_BNE:       state_d = S_BNE;
`endif
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR: state_d = (Op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  state_d = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWB:  state_d = S_FETCH;
            S_MEMWR:  state_d = mem_ready ? S_FETCH : S_MEMWR;
            S_EXEC:   state_d = S_ALUWB;
            S_ALUWB:  state_d = S_FETCH;
            S_BEQ:    state_d = S_FETCH;
            S_ADDIEX: state_d = S_ADDIWB;
            S_ADDIWB: state_d = S_FETCH;
            S_JUMP:   state_d = S_FETCH;
`ifdef MIPS_CTRL_BNE_EN
            S_BNE:    state_d = S_FETCH;
`endif
            // Unused encodings recover to FETCH with every strobe low.
            default:  state_d = S_FETCH;
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode. Outputs that a state does not drive stay 0,
    // including ALUControl.
    // ------------------------------------------------------------------
    always_comb begin
        PCEn       = 1'b0;
        IorD       = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        RegDest    = 1'b0;
        MemtoReg   = 1'b0;
        RegWrite   = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = SRCB_REG;
        ALUControl = 3'b000;
        PCSrc      = PC_ALU;
        illegal    = 1'b0;

        case (state_q)
            S_FETCH: begin
                // PC+4 is computed every cycle. PC and IR load only when
                // memory returns the instruction word.
                ALUSrcB    = SRCB_FOUR;
                ALUControl = ALU_ADD;
                IRWrite    = mem_ready;
                PCEn       = mem_ready;
            end
            S_DECODE: begin
                // Branch target PC + (imm<<2) is computed speculatively
                // into ALUOut while the register file is read.
                ALUSrcB    = SRCB_IMM4;
                ALUControl = ALU_ADD;
                case (Op)
                    OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J: illegal = 1'b0;
`ifdef MIPS_CTRL_BNE_EN
                    OP_BNE:  illegal = 1'b0;
`endif
                    default: illegal = 1'b1;
                endcase
            end
            S_MEMADR, S_ADDIEX: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = SRCB_IMM;
                ALUControl = ALU_ADD;
            end
            S_MEMRD: begin
                IorD = 1'b1;
            end
            S_MEMWB: begin
                MemtoReg = 1'b1;
                RegWrite = 1'b1;
            end
            S_MEMWR: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
            end
            S_EXEC: begin
                ALUSrcA = 1'b1;
                case (Funct)
                    FN_ADD:  ALUControl = ALU_ADD;
                    FN_SUB:  ALUControl = ALU_SUB;
                    FN_AND:  ALUControl = ALU_AND;
                    FN_OR:   ALUControl = ALU_OR;
                    FN_SLT:  ALUControl = ALU_SLT;
                    // Unknown funct is flagged but executed as add. ALUWB
                    // still writes the register.
                    default: begin
                        ALUControl = ALU_ADD;
                        illegal    = 1'b1;
                    end
                endcase
            end
            S_ALUWB: begin
                RegDest  = 1'b1;
                RegWrite = 1'b1;
            end
            S_BEQ: begin
                ALUSrcA    = 1'b1;
                ALUControl = ALU_SUB;
                PCSrc      = PC_ALUOUT;
                PCEn       = zero;
            end
`ifdef MIPS_CTRL_BNE_EN
            S_BNE: begin
                ALUSrcA    = 1'b1;
                ALUControl = ALU_SUB;
                PCSrc      = PC_ALUOUT;
                PCEn       = ~zero;
            end
`endif
            S_ADDIWB: begin
                RegWrite = 1'b1;
            end
            S_JUMP: begin
                PCSrc = PC_JUMP;
                PCEn  = 1'b1;
            end
            default: begin
                // Unused encodings keep the defaults: every strobe is low.
            end
        endcase

        // While reset is high, all outputs are forced to the idle pattern.
        // A write strobe therefore cannot continue after reset is asserted,
        // even within the cycle in which reset arrives.
        if (reset) begin
            PCEn       = 1'b0;
            IorD       = 1'b0;
            MemWrite   = 1'b0;
            IRWrite    = 1'b0;
            RegDest    = 1'b0;
            MemtoReg   = 1'b0;
            RegWrite   = 1'b0;
            ALUSrcA    = 1'b0;
            ALUSrcB    = SRCB_REG;
            ALUControl = ALU_ADD;
            PCSrc      = PC_ALU;
            illegal    = 1'b0;
        end
    end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed testbench for mips_multicycle_ctrl. Inputs are driven and outputs
// are sampled after the falling clock edge. The controls are packed into one
// word and compared with hand-built constants.

module tb_mips_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] Op;
    logic [5:0] Funct;
    logic       zero;
    logic       mem_ready;
    logic       PCEn, IorD, MemWrite, IRWrite, RegDest, MemtoReg, RegWrite, ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [2:0] ALUControl;
    logic [1:0] PCSrc;
    logic [3:0] state;
    logic       illegal;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mips_multicycle_ctrl #(.STATE_W(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .Op         (Op),
        .Funct      (Funct),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .PCEn       (PCEn),
        .IorD       (IorD),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .RegDest    (RegDest),
        .MemtoReg   (MemtoReg),
        .RegWrite   (RegWrite),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ALUControl (ALUControl),
        .PCSrc      (PCSrc),
        .state      (state),
        .illegal    (illegal)
    );

    // Packed controls:
    // {PCEn,IorD,MemWrite,IRWrite,RegDest,MemtoReg,RegWrite,ALUSrcA,ALUSrcB,ALUControl,PCSrc,illegal}
    logic [15:0] cw;
    assign cw = {PCEn, IorD, MemWrite, IRWrite, RegDest, MemtoReg, RegWrite, ALUSrcA,
                 ALUSrcB, ALUControl, PCSrc, illegal};

    function automatic logic [15:0] mk(input logic pcen, input logic iord, input logic memw,
                                       input logic irw, input logic regd, input logic m2r,
                                       input logic regw, input logic srca, input logic [1:0] srcb,
                                       input logic [2:0] aluc, input logic [1:0] pcsrc,
                                       input logic ill);
        return {pcen, iord, memw, irw, regd, m2r, regw, srca, srcb, aluc, pcsrc, ill};
    endfunction

    localparam logic [15:0] CW_RST    = mk(0,0,0,0,0,0,0,0, 2'b00, 3'b010, 2'b00, 0);
    localparam logic [15:0] CW_F1     = mk(1,0,0,1,0,0,0,0, 2'b01, 3'b010, 2'b00, 0);
    localparam logic [15:0] CW_F0     = mk(0,0,0,0,0,0,0,0, 2'b01, 3'b010, 2'b00, 0);
    localparam logic [15:0] CW_DEC    = mk(0,0,0,0,0,0,0,0, 2'b11, 3'b010, 2'b00, 0);
    localparam logic [15:0] CW_DECI   = mk(0,0,0,0,0,0,0,0, 2'b11, 3'b010, 2'b00, 1);
    localparam logic [15:0] CW_MADR   = mk(0,0,0,0,0,0,0,1, 2'b10, 3'b010, 2'b00, 0);
    localparam logic [15:0] CW_MRD    = mk(0,1,0,0,0,0,0,0, 2'b00, 3'b000, 2'b00, 0);
    localparam logic [15:0] CW_MWB    = mk(0,0,0,0,0,1,1,0, 2'b00, 3'b000, 2'b00, 0);
    localparam logic [15:0] CW_MWR    = mk(0,1,1,0,0,0,0,0, 2'b00, 3'b000, 2'b00, 0);
    localparam logic [15:0] CW_ALUWB  = mk(0,0,0,0,1,0,1,0, 2'b00, 3'b000, 2'b00, 0);
    localparam logic [15:0] CW_ADDIWB = mk(0,0,0,0,0,0,1,0, 2'b00, 3'b000, 2'b00, 0);
    localparam logic [15:0] CW_JUMP   = mk(1,0,0,0,0,0,0,0, 2'b00, 3'b000, 2'b10, 0);
    localparam logic [15:0] CW_BR1    = mk(1,0,0,0,0,0,0,1, 2'b00, 3'b110, 2'b01, 0);
    localparam logic [15:0] CW_BR0    = mk(0,0,0,0,0,0,0,1, 2'b00, 3'b110, 2'b01, 0);

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_BAD  = 6'b111111;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [3:0] est, input logic [15:0] ecw);
        check({tag, " state"}, 32'(state), 32'(est));
        check({tag, " ctrl"},  32'(cw),    32'(ecw));
    endtask

    // One cycle: drive inputs after the falling edge, then check the state
    // and outputs before the next rising edge advances the FSM.
    task automatic step(input string tag, input logic [5:0] op, input logic [5:0] fn,
                        input logic z, input logic rdy, input logic [3:0] est,
                        input logic [15:0] ecw);
        @(negedge clk);
        Op        = op;
        Funct     = fn;
        zero      = z;
        mem_ready = rdy;
        #1;
        chk_out(tag, est, ecw);
    endtask

    logic [5:0] fn_tab  [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    logic [2:0] alu_tab [5] = '{3'b010,    3'b110,    3'b000,    3'b001,    3'b111};

    initial begin
        reset = 1'b1; Op = OP_R; Funct = 6'b100000; zero = 1'b0; mem_ready = 1'b0;

        // Reset state
        @(negedge clk); #1;
        chk_out("reset", 4'd0, CW_RST);
        @(negedge clk);
        reset = 1'b0;

        // R-type add; reset arrives while the FSM is in EXEC
        step("radd F", OP_R, 6'b100000, 0, 1, 4'd0, CW_F1);
        step("radd D", OP_R, 6'b100000, 0, 1, 4'd1, CW_DEC);
        step("radd E", OP_R, 6'b100000, 0, 1, 4'd6, mk(0,0,0,0,0,0,0,1, 2'b00, 3'b010, 2'b00, 0));
        reset = 1'b1;
        #1;
        chk_out("rst async", 4'd0, CW_RST);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk_out("rst hold", 4'd0, CW_RST);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk_out("post-rst F", 4'd0, CW_F1);
        step("post-rst D", OP_R, 6'b100000, 0, 1, 4'd1, CW_DEC);
        step("post-rst E", OP_R, 6'b100000, 0, 1, 4'd6, mk(0,0,0,0,0,0,0,1, 2'b00, 3'b010, 2'b00, 0));
        step("post-rst W", OP_R, 6'b100000, 0, 1, 4'd7, CW_ALUWB);

        // R-type funct table
        for (int i = 0; i < 5; i++) begin
            step("rtab F", OP_R, fn_tab[i], 0, 1, 4'd0, CW_F1);
            step("rtab D", OP_R, fn_tab[i], 0, 1, 4'd1, CW_DEC);
            step("rtab E", OP_R, fn_tab[i], 0, 1, 4'd6,
                 mk(0,0,0,0,0,0,0,1, 2'b00, alu_tab[i], 2'b00, 0));
            step("rtab W", OP_R, fn_tab[i], 0, 1, 4'd7, CW_ALUWB);
        end

        // Unsupported funct: pulses illegal, executes as add, still writes back
        step("rbad F", OP_R, 6'b000111, 0, 1, 4'd0, CW_F1);
        step("rbad D", OP_R, 6'b000111, 0, 1, 4'd1, CW_DEC);
        step("rbad E", OP_R, 6'b000111, 0, 1, 4'd6, mk(0,0,0,0,0,0,0,1, 2'b00, 3'b010, 2'b00, 1));
        step("rbad W", OP_R, 6'b000111, 0, 1, 4'd7, CW_ALUWB);

        // lw with no wait states: 0,1,2,3,4
        step("lw F",  OP_LW, 6'd0, 0, 1, 4'd0, CW_F1);
        step("lw D",  OP_LW, 6'd0, 0, 1, 4'd1, CW_DEC);
        step("lw A",  OP_LW, 6'd0, 0, 1, 4'd2, CW_MADR);
        step("lw R",  OP_LW, 6'd0, 0, 1, 4'd3, CW_MRD);
        step("lw WB", OP_LW, 6'd0, 0, 1, 4'd4, CW_MWB);

        // lw that waits two cycles in MEMRD
        step("lww F",  OP_LW, 6'd0, 0, 1, 4'd0, CW_F1);
        step("lww D",  OP_LW, 6'd0, 0, 1, 4'd1, CW_DEC);
        step("lww A",  OP_LW, 6'd0, 0, 1, 4'd2, CW_MADR);
        step("lww R0", OP_LW, 6'd0, 0, 0, 4'd3, CW_MRD);
        step("lww R1", OP_LW, 6'd0, 0, 0, 4'd3, CW_MRD);
        step("lww R2", OP_LW, 6'd0, 0, 1, 4'd3, CW_MRD);
        step("lww WB", OP_LW, 6'd0, 0, 1, 4'd4, CW_MWB);

        // sw: FETCH waits twice, then MEMWR waits twice with MemWrite held
        step("sw F0", OP_SW, 6'd0, 0, 0, 4'd0, CW_F0);
        step("sw F1", OP_SW, 6'd0, 0, 0, 4'd0, CW_F0);
        step("sw F2", OP_SW, 6'd0, 0, 1, 4'd0, CW_F1);
        step("sw D",  OP_SW, 6'd0, 0, 1, 4'd1, CW_DEC);
        step("sw A",  OP_SW, 6'd0, 0, 1, 4'd2, CW_MADR);
        step("sw W0", OP_SW, 6'd0, 0, 0, 4'd5, CW_MWR);
        step("sw W1", OP_SW, 6'd0, 0, 0, 4'd5, CW_MWR);
        step("sw W2", OP_SW, 6'd0, 0, 1, 4'd5, CW_MWR);

        // beq taken and not taken
        step("beq1 F", OP_BEQ, 6'd0, 1, 1, 4'd0, CW_F1);
        step("beq1 D", OP_BEQ, 6'd0, 1, 1, 4'd1, CW_DEC);
        step("beq1 B", OP_BEQ, 6'd0, 1, 1, 4'd8, CW_BR1);
        step("beq0 F", OP_BEQ, 6'd0, 0, 1, 4'd0, CW_F1);
        step("beq0 D", OP_BEQ, 6'd0, 0, 1, 4'd1, CW_DEC);
        step("beq0 B", OP_BEQ, 6'd0, 0, 1, 4'd8, CW_BR0);

        // addi
        step("addi F", OP_ADDI, 6'd0, 0, 1, 4'd0, CW_F1);
        step("addi D", OP_ADDI, 6'd0, 0, 1, 4'd1, CW_DEC);
        step("addi X", OP_ADDI, 6'd0, 0, 1, 4'd9, CW_MADR);
        step("addi W", OP_ADDI, 6'd0, 0, 1, 4'd10, CW_ADDIWB);

        // j
        step("j F", OP_J, 6'd0, 0, 1, 4'd0, CW_F1);
        step("j D", OP_J, 6'd0, 0, 1, 4'd1, CW_DEC);
        step("j J", OP_J, 6'd0, 0, 1, 4'd11, CW_JUMP);

        // bne (Op=000101)
        step("bne F", OP_BNE, 6'd0, 0, 1, 4'd0, CW_F1);
`ifdef MIPS_CTRL_BNE_EN
        step("bne D", OP_BNE, 6'd0, 0, 1, 4'd1, CW_DEC);
        step("bne B", OP_BNE, 6'd0, 0, 1, 4'd12, CW_BR1);
`else
        step("bne D", OP_BNE, 6'd0, 0, 1, 4'd1, CW_DECI);
`endif

        // Unknown opcode pulses illegal and goes back to FETCH
        step("bad F", OP_BAD, 6'd0, 0, 1, 4'd0, CW_F1);
        step("bad D", OP_BAD, 6'd0, 0, 1, 4'd1, CW_DECI);
        step("bad F2", OP_BAD, 6'd0, 0, 0, 4'd0, CW_F0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

endmodule
